seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the picoMIPS combinational ALU.
- Provides the same 8-function set at width N, with signed fixed-point multiply.
- The multiply is a sequential shift-add engine (area-cheap on small FPGAs); all other functions complete in one cycle.
- Sits between the register file and writeback; the controller uses a start/ready/done handshake and stalls on !ready.

Parameters:
- N, 8, operand/result width; legal range 4..32.
- FRAC, N-1, fractional bits of the fixed-point format (Q(N-FRAC).FRAC); legal range 0..N-1. The MUL result is product[FRAC+N-1:FRAC].

Ports:
- clk  input  1  system clock, rising edge
- nReset  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- func  input  3  function code (alu_pkg codes)
- a  input  N  operand A, sampled on the accepting edge
- b  input  N  operand B, sampled on the accepting edge
- ready  output  1  idle, or in final (done) cycle; can accept start
- done  output  1  one-cycle pulse: result/flags valid
- result  output  N  registered result, held until next done
- flags  output  4  registered {V,N,Z,C}, held until next done

Behaviour:
- Reset (async, nReset=0): state=IDLE, ready=1, done=0, result=0, flags=0, iteration counter=0. Reset mid-MUL aborts the operation; no done is produced.
- Acceptance edge E0 = rising edge with start&ready. It latches a, b, func. start while ready=0 is ignored (no queueing).
- FSM states:
  - IDLE: on accept with func!=MUL, go to IDLE; result/flags/done registered at E0+1 cycle. On accept with func==MUL, go to MULT.
  - MULT: N cycles. Take operand magnitudes; per cycle, add multiplicand if the multiplier LSB=1, then shift; the counter counts N-1..0.
  - FIN: apply sign fix (sign = a[N-1]^b[N-1]), select product[FRAC+N-1:FRAC], compute V, register outputs, then go to IDLE.
- Latency: non-MUL ops give done in the cycle after E0. MUL gives done after edge E0+N+2.
- ready is low from E0 until done rises. ready=1 during the done cycle, so back-to-back issue is allowed.
- Functions:
  - NOP: result=a, V=C=0.
  - A: result=a. B: result=b.
  - ADD: a+b.
  - SUB: a-b.
  - MUL: as above.
  - AND: a&b. OR: a|b.
- Flags:
  - V (ADD/SUB): signed overflow of the N-bit two's complement result.
  - V (MUL): set when the full 2N-bit product bits above FRAC+N-1 are not all equal to result[N-1]. Covers the -1.0*-1.0 case.
  - C (ADD): carry out of the MSB.
  - C (SUB): inverted carry, i.e. 1 = borrow (picoMIPS convention).
  - C: 0 for all other functions.
  - Z = (result==0). N = result[N-1]. Both are computed from the final registered result.
- Undefined func codes behave as NOP.
- Width: internal product register is 2N bits. No truncation occurs before the FIN selection.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: on ADD/SUB/MUL with V=1, result clamps to the signed max (0111..1) if the expected sign is positive, else to the signed min (1000..0). V is still reported as 1. N and Z reflect the clamped value.
- Undefined: wrap-around results as specified above. No saturation logic is synthesised.

Decomposition:
- Package alu_pkg:
  - enum alu_func_t: RNOP, RA, RB, RADD, RSUB, RMUL, RAND, ROR (3-bit, existing code values retained).
  - Flag index constants FLAG_V=3, FLAG_N=2, FLAG_Z=1, FLAG_C=0.
  - FSM state enum: IDLE, MULT, FIN.
- One sub-module, seq_mul: shift-add magnitude multiplier with its own counter, start/busy interface, and 2N-bit product output.
- seq_alu owns the handshake, the single-cycle datapath, sign fix, flags, and saturation.

Test Plan (N=8, FRAC=7):
- MUL a=0x40, b=0x40 (0.5×0.5) → done exactly 10 cycles after E0; result=0x20, flags=0000.
- MUL a=0x80, b=0x80 (-1×-1):
  - without ALU_SAT_EN → result=0x80, flags V=1, N=1.
  - with ALU_SAT_EN → result=0x7F, V=1, N=0.
- ADD a=0x7F, b=0x01 → next-cycle done; result=0x80, V=1, N=1, C=0. With ALU_SAT_EN, result=0x7F.
- SUB a=0x00, b=0x01 → result=0xFF, N=1, C=1 (borrow), V=0. SUB 0x05-0x05 → result=0x00, Z=1, C=0.
- Sequence of handshake checks:
  - Start MUL, then pulse start with ADD during MULT → ignored; only the MUL done appears.
  - Issue ADD in the done cycle → accepted; its done follows one cycle later.
- Assert nReset=0 at cycle 4 of a MUL → outputs 0 and ready=1 immediately. No done occurs. A subsequent MUL 0x20×0x20 gives result=0x08.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: function codes, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    RNOP = 3'd0,
    RA   = 3'd1,
    RB   = 3'd2,
    RADD = 3'd3,
    RSUB = 3'd4,
    RMUL = 3'd5,
    RAND = 3'd6,
    ROR  = 3'd7
  } alu_func_t;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// Shift-add unsigned magnitude multiplier: one partial-product step per cycle for N cycles,
// full 2N-bit product held in the accumulator once busy drops.
module seq_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           nReset,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           busy,
  output logic           last,
  output logic [2*N-1:0] product
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0]  cnt;
  logic [N-1:0]   mcand_r;
  logic [2*N-1:0] acc;
  logic [N:0]     partial;

  // Upper half accumulates the multiplicand; lower half starts as the multiplier and shifts out.
  assign partial = acc[0] ? ({1'b0, acc[2*N-1:N]} + {1'b0, mcand_r})
                          : {1'b0, acc[2*N-1:N]};

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(N - 1);
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mcand_r <= mcand;
      acc     <= {{N{1'b0}}, mplier};
    end else if (busy) begin
      acc <= {partial, acc[N-1:1]};
    end
  end

  assign last    = (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// Registered N-bit ALU with start/ready/done handshake and a sequential fixed-point multiply.
// Optional macro ALU_SAT_EN clamps overflowing ADD/SUB/MUL results to the signed limits.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N    = 8,
  parameter int FRAC = N - 1
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  input  logic [2:0]   func,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  state_t state;
  logic   mul_go;

  logic signed [N-1:0] a_p0, b_p0;

  logic signed [N-1:0] res_c, alu_res;
  logic                v_c, c_c;

  logic [N-1:0]          mag_a, mag_b;
  logic [2*N-1:0]        product;
  logic                  mul_busy, mul_last, neg;
  logic signed [2*N-1:0] prod_s, prod_hi;
  logic signed [N-1:0]   mul_raw, mul_res;
  logic                  mul_v;

  function automatic logic [3:0] pack_flags(input logic [N-1:0] r, input logic ovf,
                                            input logic cy);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = ovf;
    f[FLAG_N] = r[N-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = cy;
    return f;
  endfunction

  // Single-cycle datapath, evaluated straight from the accepted operands.
  always_comb begin
    res_c = a;
    v_c   = 1'b0;
    c_c   = 1'b0;
    case (alu_func_t'(func))
      RA:   res_c = a;
      RB:   res_c = b;
      RADD: begin
        {c_c, res_c} = {1'b0, a} + {1'b0, b};
        v_c = (a[N-1] == b[N-1]) && (res_c[N-1] != a[N-1]);
      end
      RSUB: begin
        {c_c, res_c} = {1'b0, a} - {1'b0, b};
        v_c = (a[N-1] != b[N-1]) && (res_c[N-1] != a[N-1]);
      end
      RAND: res_c = a & b;
      ROR:  res_c = a | b;
      default: res_c = a;
    endcase
  end

  // Multiply: magnitudes in, sign restored on the full 2N-bit product before selection.
  assign mag_a   = a_p0[N-1] ? N'(-a_p0) : a_p0;
  assign mag_b   = b_p0[N-1] ? N'(-b_p0) : b_p0;
  assign neg     = a_p0[N-1] ^ b_p0[N-1];
  assign prod_s  = neg ? -$signed(product) : $signed(product);
  assign mul_raw = prod_s[FRAC+N-1:FRAC];
  assign prod_hi = prod_s >>> (FRAC + N - 1);
  assign mul_v   = !((prod_hi == '0) || (prod_hi == '1));

`ifdef ALU_SAT_EN
  function automatic logic [N-1:0] saturate(input logic [N-1:0] val, input logic ovf,
                                            input logic sgn);
    if (ovf) return sgn ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    return val;
  endfunction

  // Overflowing ADD/SUB keeps the sign of a; MUL keeps the sign of the true product.
  assign alu_res = saturate(res_c, v_c, a[N-1]);
  assign mul_res = saturate(mul_raw, mul_v, neg);
`else
  assign alu_res = res_c;
  assign mul_res = mul_raw;
`endif

  seq_mul #(.N(N)) u_mul (
    .clk    (clk),
    .nReset (nReset),
    .start  (mul_go),
    .mcand  (mag_a),
    .mplier (mag_b),
    .busy   (mul_busy),
    .last   (mul_last),
    .product(product)
  );

  always_ff @(posedge clk) begin
    if (start && ready) begin
      a_p0 <= a;
      b_p0 <= b;
    end
  end

  // Handshake FSM: IDLE accepts, MULT waits on the engine, FIN publishes the product.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      flags  <= '0;
      mul_go <= 1'b0;
    end else begin
      done   <= 1'b0;
      mul_go <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (alu_func_t'(func) == RMUL) begin
              state  <= MULT;
              ready  <= 1'b0;
              mul_go <= 1'b1;
            end else begin
              result <= alu_res;
              flags  <= pack_flags(alu_res, v_c, c_c);
              done   <= 1'b1;
            end
          end
        end
        MULT: begin
          if (mul_busy && mul_last) state <= FIN;
        end
        FIN: begin
          result <= mul_res;
          flags  <= pack_flags(mul_res, mul_v, 1'b0);
          done   <= 1'b1;
          ready  <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (N=8, FRAC=7); expected values switch with ALU_SAT_EN.
module tb_seq_alu;
  import alu_pkg::*;

  logic       clk;
  logic       nReset;
  logic       start;
  logic [2:0] func;
  logic [7:0] a, b;
  logic       ready, done;
  logic [7:0] result;
  logic [3:0] flags;

  int vectors;
  int miscompares;

  seq_alu #(.N(8), .FRAC(7)) dut (
    .clk   (clk),
    .nReset(nReset),
    .start (start),
    .func  (func),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .result(result),
    .flags (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic issue(input alu_func_t f, input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    func  = f;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    start  = 1'b0;
    func   = 3'd0;
    a      = 8'h00;
    b      = 8'h00;
    #12;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset ready: got %b want 1", ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", done); end
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL reset result: got %h want 00", result); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset flags: got %b want 0000", flags); end
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul_half;
    int cyc;
    issue(RMUL, 8'h40, 8'h40);
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL mul_half ready_low: got %b want 0", ready); end
    wait_done(cyc);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL mul_half latency: got %0d want 10", cyc); end
    vectors++; if (result !== 8'h20) begin miscompares++; $display("FAIL mul_half result: got %h want 20", result); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL mul_half flags: got %b want 0000", flags); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL mul_half ready_in_done: got %b want 1", ready); end
    @(posedge clk);
    #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mul_half done_pulse: got %b want 0", done); end
    vectors++; if (result !== 8'h20) begin miscompares++; $display("FAIL mul_half result_hold: got %h want 20", result); end
  endtask

  task automatic test_mul_signed;
    int cyc;
    logic [7:0] exp_r;
    logic [3:0] exp_f;
`ifdef ALU_SAT_EN
    exp_r = 8'h7F;
    exp_f = 4'b1000;
`else
    exp_r = 8'h80;
    exp_f = 4'b1100;
`endif
    issue(RMUL, 8'h80, 8'h80);
    wait_done(cyc);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL mul_m1m1 latency: got %0d want 10", cyc); end
    vectors++; if (result !== exp_r) begin miscompares++; $display("FAIL mul_m1m1 result: got %h want %h", result, exp_r); end
    vectors++; if (flags !== exp_f) begin miscompares++; $display("FAIL mul_m1m1 flags: got %b want %b", flags, exp_f); end

    issue(RMUL, 8'hC0, 8'h40);
    wait_done(cyc);
    vectors++; if (result !== 8'hE0) begin miscompares++; $display("FAIL mul_neg result: got %h want e0", result); end
    vectors++; if (flags !== 4'b0100) begin miscompares++; $display("FAIL mul_neg flags: got %b want 0100", flags); end

    issue(RMUL, 8'h00, 8'h80);
    wait_done(cyc);
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL mul_zero result: got %h want 00", result); end
    vectors++; if (flags !== 4'b0010) begin miscompares++; $display("FAIL mul_zero flags: got %b want 0010", flags); end
  endtask

  task automatic test_add;
    logic [7:0] exp_r;
    logic [3:0] exp_f;
`ifdef ALU_SAT_EN
    exp_r = 8'h7F;
    exp_f = 4'b1000;
`else
    exp_r = 8'h80;
    exp_f = 4'b1100;
`endif
    issue(RADD, 8'h7F, 8'h01);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL add_ovf done: got %b want 1", done); end
    vectors++; if (result !== exp_r) begin miscompares++; $display("FAIL add_ovf result: got %h want %h", result, exp_r); end
    vectors++; if (flags !== exp_f) begin miscompares++; $display("FAIL add_ovf flags: got %b want %b", flags, exp_f); end

    issue(RADD, 8'hFF, 8'h01);
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL add_carry result: got %h want 00", result); end
    vectors++; if (flags !== 4'b0011) begin miscompares++; $display("FAIL add_carry flags: got %b want 0011", flags); end
  endtask

  task automatic test_sub;
    issue(RSUB, 8'h00, 8'h01);
    vectors++; if (result !== 8'hFF) begin miscompares++; $display("FAIL sub_borrow result: got %h want ff", result); end
    vectors++; if (flags !== 4'b0101) begin miscompares++; $display("FAIL sub_borrow flags: got %b want 0101", flags); end
    issue(RSUB, 8'h05, 8'h05);
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL sub_zero result: got %h want 00", result); end
    vectors++; if (flags !== 4'b0010) begin miscompares++; $display("FAIL sub_zero flags: got %b want 0010", flags); end
  endtask

  task automatic test_logic;
    issue(RAND, 8'hF0, 8'h3C);
    vectors++; if (result !== 8'h30) begin miscompares++; $display("FAIL and result: got %h want 30", result); end
    issue(ROR, 8'h81, 8'h02);
    vectors++; if (result !== 8'h83) begin miscompares++; $display("FAIL or result: got %h want 83", result); end
    vectors++; if (flags !== 4'b0100) begin miscompares++; $display("FAIL or flags: got %b want 0100", flags); end
    issue(RA, 8'h12, 8'h34);
    vectors++; if (result !== 8'h12) begin miscompares++; $display("FAIL pass_a result: got %h want 12", result); end
    issue(RB, 8'h12, 8'h34);
    vectors++; if (result !== 8'h34) begin miscompares++; $display("FAIL pass_b result: got %h want 34", result); end
    issue(RNOP, 8'h00, 8'h55);
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL nop result: got %h want 00", result); end
    vectors++; if (flags !== 4'b0010) begin miscompares++; $display("FAIL nop flags: got %b want 0010", flags); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int extra_done;
    cyc        = -1;
    extra_done = 0;
    issue(RMUL, 8'h40, 8'h40);
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin
        start = 1'b1;
        func  = RADD;
        a     = 8'h01;
        b     = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
    start = 1'b0;
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL ignore_start first_done: got %0d want 10", cyc); end
    vectors++; if (result !== 8'h20) begin miscompares++; $display("FAIL ignore_start result: got %h want 20", result); end
    issue(RADD, 8'h03, 8'h04);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b done: got %b want 1", done); end
    vectors++; if (result !== 8'h07) begin miscompares++; $display("FAIL b2b result: got %h want 07", result); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL b2b flags: got %b want 0000", flags); end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) extra_done++;
    end
    vectors++; if (extra_done != 0) begin miscompares++; $display("FAIL b2b stray_done: got %0d want 0", extra_done); end
  endtask

  task automatic test_reset_mid_mul;
    int cyc;
    int stray;
    stray = 0;
    issue(RMUL, 8'h40, 8'h40);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    #2;
    nReset = 1'b0;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset ready: got %b want 1", ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_reset done: got %b want 0", done); end
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL mid_reset result: got %h want 00", result); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL mid_reset flags: got %b want 0000", flags); end
    @(posedge clk);
    @(negedge clk);
    nReset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done) stray++;
    end
    vectors++; if (stray != 0) begin miscompares++; $display("FAIL mid_reset stray_done: got %0d want 0", stray); end
    issue(RMUL, 8'h20, 8'h20);
    wait_done(cyc);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL post_reset latency: got %0d want 10", cyc); end
    vectors++; if (result !== 8'h08) begin miscompares++; $display("FAIL post_reset result: got %h want 08", result); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL post_reset flags: got %b want 0000", flags); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_mul_half();
    test_mul_signed();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
